board_mem: RTL and testbench
============================

BOARD_MEM -- requirements
Module: board_mem

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: req  input  1  request strobe from the move datapath.
REQ-004 SHALL have port: wren  input  1  1 = write request, 0 = read request; sampled with req.
REQ-005 SHALL have port: addr_to_mem  input  7  cell address, row*10+col, 10x10 board including walls.
REQ-006 SHALL have port: data_to_mem  input  2  write data: 00 null, 01 black, 10 white, 11 wall.
REQ-007 SHALL have port: ready  output  1  high when a request can be accepted.
REQ-008 SHALL have port: data_get  output  1  one-cycle completion pulse for every accepted request.
REQ-009 SHALL have port: data_from_mem  output  2  read data, valid while data_get is high.
REQ-010 SHALL have ports: black_count, white_count  output  7  live piece counts, present only under BOARD_COUNT_EN.

Function
REQ-011 SHALL store 100 two-bit cells at addresses 0..99.
REQ-012 SHALL implement FSM states INIT, IDLE and RESP.
REQ-013 INIT SHALL write one cell per cycle, addresses 0..99 ascending, then move to IDLE; INIT lasts exactly 100 cycles.
REQ-014 INIT pattern SHALL be: wall (11) where row or col is 0 or 9; 44 = white, 45 = black, 54 = black, 55 = white; all other cells null.
REQ-015 ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when req && ready, and the FSM SHALL then go IDLE->RESP.
REQ-017 In RESP, data_get SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 Read latency SHALL be 1 cycle: data_from_mem shows the cell value as of the accept edge.
REQ-019 Writes SHALL commit on the accept edge; a read accepted in the next IDLE SHALL see the new value.
REQ-020 Reads of addresses 100..127 SHALL return 11; writes to them SHALL be ignored; data_get SHALL still pulse.
REQ-021 Writes to wall cells, and writes of data 11 to any cell, SHALL be ignored; data_get SHALL still pulse.
REQ-022 req while ready = 0 (INIT or RESP) SHALL be ignored, with no queueing.
REQ-023 data_from_mem SHALL be 00 whenever data_get = 0.
REQ-024 Maximum throughput SHALL be one request per 2 cycles.

Reset
REQ-025 reset SHALL force the FSM to INIT, set the INIT address to 0, and drive ready = 0, data_get = 0 and data_from_mem = 00.
REQ-026 A reset asserted mid-INIT or in RESP SHALL restart INIT from address 0, and the pending data_get SHALL be dropped.
REQ-027 Counts SHALL read 0 during INIT and 2/2 on the first IDLE cycle.

Configuration
REQ-028 Macro BOARD_COUNT_EN SHALL include black_count/white_count and their update logic.
REQ-029 With BOARD_COUNT_EN, an effective write SHALL decrement the count of the old value (if black or white) and increment the count of the new value on the same edge; counts SHALL change by no more than 1 per request and stay within 0..64.
REQ-030 Without BOARD_COUNT_EN, the ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package othello_pkg SHALL hold: cell encodings CELL_NULL, CELL_BLACK, CELL_WHITE, CELL_WALL; BOARD_DIM = 10; BOARD_CELLS = 100; the four centre start addresses; and the FSM state typedef.
REQ-032 Sub-module board_init_pattern SHALL be combinational, mapping a 7-bit address to its INIT cell value, and SHALL be reused by the bench model.

Verification
REQ-033 Reset, then 100 cycles: ready rises on cycle 101; reading 0, 44, 45 and 33 returns 11, 10, 01 and 00 respectively; counts are 2/2.
REQ-034 Write 01 to 33, then read 33: data_get pulses 1 cycle after each accept, the read returns 01, black_count = 3.
REQ-035 Write 01 to 44 (white->black): black_count = 3, white_count = 1; a subsequent read of 44 returns 01.
REQ-036 Write 01 to 0, write 11 to 33, and read 120: each data_get pulses; reads of 0 and 33 then return 11 and 00; the read of 120 returns 11; counts are unchanged.
REQ-037 Hold req high continuously: accepts occur every 2 cycles only, and req during INIT produces no data_get.
REQ-038 Assert reset during the RESP cycle and again at INIT address 50: no data_get is produced, INIT restarts, and ready rises 100 cycles after reset is released.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared encodings, board geometry and FSM state constants for the Othello board memory.
package othello_pkg;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned CELL_W      = 2;
  localparam int unsigned COUNT_W     = 7;
  localparam int unsigned BOARD_DIM   = 10;
  localparam int unsigned BOARD_CELLS = 100;

  localparam logic [CELL_W-1:0] CELL_NULL  = 2'b00;
  localparam logic [CELL_W-1:0] CELL_BLACK = 2'b01;
  localparam logic [CELL_W-1:0] CELL_WHITE = 2'b10;
  localparam logic [CELL_W-1:0] CELL_WALL  = 2'b11;

  // Centre start squares: 44/55 white, 45/54 black.
  localparam logic [ADDR_W-1:0] START_WHITE_0 = 7'd44;
  localparam logic [ADDR_W-1:0] START_BLACK_0 = 7'd45;
  localparam logic [ADDR_W-1:0] START_BLACK_1 = 7'd54;
  localparam logic [ADDR_W-1:0] START_WHITE_1 = 7'd55;

  typedef logic [1:0] board_state_t;
  localparam board_state_t ST_INIT = 2'd0;
  localparam board_state_t ST_IDLE = 2'd1;
  localparam board_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/board_init_pattern.sv
// Combinational map from cell address to its power-up value (walls, centre pieces, null).
module board_init_pattern
  import othello_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [CELL_W-1:0] cell_c
);

  localparam logic [ADDR_W-1:0] DIM_A   = ADDR_W'(BOARD_DIM);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(BOARD_DIM - 1);
  localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(BOARD_CELLS);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  always_comb begin
    cell_c = CELL_NULL;
    row    = addr / DIM_A;
    col    = addr % DIM_A;
    // Anything off the 10x10 board reads as wall too.
    if (addr >= CELLS_A) begin
      cell_c = CELL_WALL;
    end else if (row == '0 || row == LAST_A || col == '0 || col == LAST_A) begin
      cell_c = CELL_WALL;
    end else if (addr == START_WHITE_0 || addr == START_WHITE_1) begin
      cell_c = CELL_WHITE;
    end else if (addr == START_BLACK_0 || addr == START_BLACK_1) begin
      cell_c = CELL_BLACK;
    end
  end

endmodule

// File: rtl/board_mem.sv
// Othello board store: 100 two-bit cells, self-initialising, one request per two cycles.
// Optional live piece counters are built when BOARD_COUNT_EN is defined.
module board_mem
  import othello_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr_to_mem,
  input  logic [CELL_W-1:0] data_to_mem,
  output logic              ready,
  output logic              data_get,
  output logic [CELL_W-1:0] data_from_mem
`ifdef BOARD_COUNT_EN
  ,
  output logic [COUNT_W-1:0] black_count,
  output logic [COUNT_W-1:0] white_count
`endif
);

  localparam logic [ADDR_W-1:0] CELLS_A     = ADDR_W'(BOARD_CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL_A = ADDR_W'(BOARD_CELLS - 1);

  board_state_t      state;
  board_state_t      state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic [CELL_W-1:0] init_cell_c;
  logic [CELL_W-1:0] mem [BOARD_CELLS];

  logic              in_range_c;
  logic [CELL_W-1:0] cur_cell_c;
  logic              accept_c;
  logic              wr_eff_c;

  board_init_pattern u_init_pattern (
    .addr   (init_addr),
    .cell_c (init_cell_c)
  );

  // Request decode; a write is dropped for off-board, wall targets and wall data.
  always_comb begin
    in_range_c = (addr_to_mem < CELLS_A);
    cur_cell_c = in_range_c ? mem[addr_to_mem] : CELL_WALL;
    accept_c   = req && (state == ST_IDLE);
    wr_eff_c   = accept_c && wren && in_range_c &&
                 (cur_cell_c != CELL_WALL) && (data_to_mem != CELL_WALL);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_addr == LAST_CELL_A) state_nxt = ST_IDLE;
      ST_IDLE: if (req) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_addr <= init_addr + ADDR_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready         <= 1'b0;
      data_get      <= 1'b0;
      data_from_mem <= CELL_NULL;
    end else begin
      ready         <= (state_nxt == ST_IDLE);
      data_get      <= (state_nxt == ST_RESP);
      data_from_mem <= (accept_c && !wren) ? cur_cell_c : CELL_NULL;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[init_addr] <= init_cell_c;
      end else if (wr_eff_c) begin
        mem[addr_to_mem] <= data_to_mem;
      end
    end
  end

`ifdef BOARD_COUNT_EN
  // Counts stay 0 through INIT and load the start position on the final INIT edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      black_count <= '0;
      white_count <= '0;
    end else if (state == ST_INIT) begin
      black_count <= (state_nxt == ST_IDLE) ? COUNT_W'(2) : '0;
      white_count <= (state_nxt == ST_IDLE) ? COUNT_W'(2) : '0;
    end else if (wr_eff_c) begin
      black_count <= black_count - COUNT_W'(cur_cell_c == CELL_BLACK)
                                 + COUNT_W'(data_to_mem == CELL_BLACK);
      white_count <= white_count - COUNT_W'(cur_cell_c == CELL_WHITE)
                                 + COUNT_W'(data_to_mem == CELL_WHITE);
    end
  end
`endif

endmodule

// File: tb/tb_board_mem.sv
// Directed self-checking bench for board_mem; count checks are active when BOARD_COUNT_EN is defined.
module tb_board_mem;
  import othello_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       req;
  logic       wren;
  logic [6:0] addr_to_mem;
  logic [1:0] data_to_mem;
  logic       ready;
  logic       data_get;
  logic [1:0] data_from_mem;
`ifdef BOARD_COUNT_EN
  logic [6:0] black_count;
  logic [6:0] white_count;
`endif

  logic [6:0] pat_addr;
  logic [1:0] pat_cell;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  board_mem dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .wren          (wren),
    .addr_to_mem   (addr_to_mem),
    .data_to_mem   (data_to_mem),
    .ready         (ready),
    .data_get      (data_get),
    .data_from_mem (data_from_mem)
`ifdef BOARD_COUNT_EN
    ,
    .black_count   (black_count),
    .white_count   (white_count)
`endif
  );

  board_init_pattern u_model (
    .addr   (pat_addr),
    .cell_c (pat_cell)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_counts(input string name, input int exp_b, input int exp_w);
`ifdef BOARD_COUNT_EN
    total++;
    if (black_count !== 7'(exp_b) || white_count !== 7'(exp_w)) begin
      bad++;
      $display("FAIL %s: black=%0d white=%0d required %0d/%0d",
               name, black_count, white_count, exp_b, exp_w);
    end
`endif
  endtask

  task automatic reinit;
    reset = 1'b1; req = 1'b0; wren = 1'b0;
    tick;
    reset = 1'b0;
    repeat (100) tick;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL reinit_ready: ready=%0b required 1", ready);
    end
  endtask

  task automatic xact(input logic wr, input logic [6:0] a, input logic [1:0] d,
                      output logic dg_acc, output logic dg_next, output logic [1:0] rd);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    if (ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL xact_wait_ready: ready=%0b required 1", ready);
    end
    req = 1'b1; wren = wr; addr_to_mem = a; data_to_mem = d;
    tick;
    req = 1'b0; wren = 1'b0;
    dg_acc = data_get;
    rd     = data_from_mem;
    tick;
    dg_next = data_get;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; wren = 1'b0; addr_to_mem = '0; data_to_mem = '0;
    tick;
    total++;
    if (ready !== 1'b0 || data_get !== 1'b0 || data_from_mem !== 2'b00) begin
      bad++;
      $display("FAIL reset_outputs: ready=%0b data_get=%0b data=%b required 0 0 00",
               ready, data_get, data_from_mem);
    end
    check_counts("reset_counts", 0, 0);
    reset = 1'b0;
    repeat (99) tick;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL init_still_busy: ready=%0b required 0", ready);
    end
    check_counts("init_counts_zero", 0, 0);
    tick;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_init: ready=%0b required 1", ready);
    end
    check_counts("first_idle_counts", 2, 2);
  endtask

  task automatic test_init_reads;
    logic [6:0] ta [4];
    logic [1:0] te [4];
    logic dg_a, dg_n;
    logic [1:0] rd;
    ta = '{7'd0, 7'd44, 7'd45, 7'd33};
    te = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, ta[i], 2'b00, dg_a, dg_n, rd);
      total++;
      if (rd !== te[i] || dg_a !== 1'b1 || dg_n !== 1'b0) begin
        bad++;
        $display("FAIL init_read_%0d: data=%b dg=%b%b required %b dg=10",
                 ta[i], rd, dg_a, dg_n, te[i]);
      end
    end
    check_counts("init_reads_counts", 2, 2);
  endtask

  task automatic test_write_read;
    logic dg_a, dg_n;
    logic [1:0] rd;
    xact(1'b1, 7'd33, 2'b01, dg_a, dg_n, rd);
    total++;
    if (dg_a !== 1'b1 || dg_n !== 1'b0 || rd !== 2'b00) begin
      bad++;
      $display("FAIL write33_pulse: dg=%b%b data=%b required dg=10 data=00", dg_a, dg_n, rd);
    end
    xact(1'b0, 7'd33, 2'b00, dg_a, dg_n, rd);
    total++;
    if (rd !== 2'b01 || dg_a !== 1'b1 || dg_n !== 1'b0) begin
      bad++;
      $display("FAIL read33_after_write: data=%b dg=%b%b required 01 dg=10", rd, dg_a, dg_n);
    end
    check_counts("write33_counts", 3, 2);
  endtask

  task automatic test_flip;
    logic dg_a, dg_n;
    logic [1:0] rd;
    reinit;
    xact(1'b1, 7'd44, 2'b01, dg_a, dg_n, rd);
    check_counts("flip44_counts", 3, 1);
    xact(1'b0, 7'd44, 2'b00, dg_a, dg_n, rd);
    total++;
    if (rd !== 2'b01) begin
      bad++;
      $display("FAIL flip44_read: data=%b required 01", rd);
    end
  endtask

  task automatic test_ignored_writes;
    logic dg_a, dg_n;
    logic [1:0] rd;
    reinit;
    xact(1'b1, 7'd0, 2'b01, dg_a, dg_n, rd);
    total++;
    if (dg_a !== 1'b1 || dg_n !== 1'b0) begin
      bad++;
      $display("FAIL wall_write_pulse: dg=%b%b required 10", dg_a, dg_n);
    end
    xact(1'b1, 7'd33, 2'b11, dg_a, dg_n, rd);
    total++;
    if (dg_a !== 1'b1 || dg_n !== 1'b0) begin
      bad++;
      $display("FAIL wall_data_pulse: dg=%b%b required 10", dg_a, dg_n);
    end
    xact(1'b1, 7'd120, 2'b01, dg_a, dg_n, rd);
    xact(1'b0, 7'd120, 2'b00, dg_a, dg_n, rd);
    total++;
    if (rd !== 2'b11 || dg_a !== 1'b1) begin
      bad++;
      $display("FAIL read120: data=%b dg=%b required 11 dg=1", rd, dg_a);
    end
    xact(1'b0, 7'd0, 2'b00, dg_a, dg_n, rd);
    total++;
    if (rd !== 2'b11) begin
      bad++;
      $display("FAIL read0_after_ignored: data=%b required 11", rd);
    end
    xact(1'b0, 7'd33, 2'b00, dg_a, dg_n, rd);
    total++;
    if (rd !== 2'b00) begin
      bad++;
      $display("FAIL read33_after_ignored: data=%b required 00", rd);
    end
    check_counts("ignored_counts", 2, 2);
  endtask

  task automatic test_board_sweep;
    logic [6:0] ha [8];
    logic [1:0] he [8];
    logic dg_a, dg_n;
    logic [1:0] rd;
    ha = '{7'd9, 7'd10, 7'd11, 7'd54, 7'd55, 7'd88, 7'd89, 7'd99};
    he = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 8; i++) begin
      pat_addr = ha[i];
      #1;
      total++;
      if (pat_cell !== he[i]) begin
        bad++;
        $display("FAIL pattern_%0d: cell=%b required %b", ha[i], pat_cell, he[i]);
      end
    end
    reinit;
    for (int a = 0; a < 128; a++) begin
      pat_addr = 7'(a);
      xact(1'b0, 7'(a), 2'b00, dg_a, dg_n, rd);
      total++;
      if (rd !== pat_cell) begin
        bad++;
        $display("FAIL sweep_%0d: data=%b required %b", a, rd, pat_cell);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dg_init;
    logic exp_dg;
    logic [1:0] exp_d;
    dg_init = 0;
    reset = 1'b1; req = 1'b1; wren = 1'b0; addr_to_mem = 7'd45;
    tick;
    reset = 1'b0;
    repeat (100) begin
      tick;
      if (data_get === 1'b1) dg_init++;
    end
    total++;
    if (dg_init != 0) begin
      bad++;
      $display("FAIL req_during_init: pulses=%0d required 0", dg_init);
    end
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp_dg = (k % 2) == 1;
      exp_d  = exp_dg ? 2'b01 : 2'b00;
      total++;
      if (data_get !== exp_dg || data_from_mem !== exp_d) begin
        bad++;
        $display("FAIL b2b_cycle_%0d: dg=%b data=%b required dg=%b data=%b",
                 k, data_get, data_from_mem, exp_dg, exp_d);
      end
    end
    req = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    logic dg_a, dg_n;
    logic [1:0] rd;
    int n;
    int dg_seen;
    xact(1'b1, 7'd33, 2'b01, dg_a, dg_n, rd);
    req = 1'b1; wren = 1'b0; addr_to_mem = 7'd33;
    tick;
    req = 1'b0;
    reset = 1'b1;
    tick;
    total++;
    if (data_get !== 1'b0 || ready !== 1'b0 || data_from_mem !== 2'b00) begin
      bad++;
      $display("FAIL reset_in_resp: dg=%b ready=%b data=%b required 0 0 00",
               data_get, ready, data_from_mem);
    end
    reset = 1'b0;
    repeat (50) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n = 0; dg_seen = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick;
      n++;
      if (data_get === 1'b1) dg_seen++;
    end
    total++;
    if (n != 100 || dg_seen != 0) begin
      bad++;
      $display("FAIL reset_mid_init: ready_after=%0d pulses=%0d required 100 0", n, dg_seen);
    end
    xact(1'b0, 7'd33, 2'b00, dg_a, dg_n, rd);
    total++;
    if (rd !== 2'b00) begin
      bad++;
      $display("FAIL read33_after_restart: data=%b required 00", rd);
    end
    check_counts("restart_counts", 2, 2);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wren = 1'b0; addr_to_mem = '0; data_to_mem = '0;
    pat_addr = '0;
    test_reset;
    test_init_reads;
    test_write_read;
    test_flip;
    test_ignored_writes;
    test_board_sweep;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
